tt_operand_sequencer: RTL and testbench
=======================================

# tt_operand_sequencer

Sequential front end for the 4-bit add/subtract datapath. Collects two 4-bit operands over a shared nibble bus with a slow, button-driven strobe and sequences the operation. Registers the 5-bit result and status onto the 8-bit tile outputs. It sits directly upstream of the 4-bit adder/subtractor stage and absorbs that stage's arithmetic as an internal sub-module, so the tile presents stable, registered results.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on the strobe and op pins (minimum 2).

Ports (tile convention):
- `io_in[0]` input 1: clock `clk`; all flops rise-edge.
- `io_in[1]` input 1: reset `rst`; asynchronous, active-high.
- `io_in[5:2]` input 4: operand nibble `d`.
- `io_in[6]` input 1: `stb`, load strobe, asynchronous to `clk`.
- `io_in[7]` input 1: `op`; 0 = add, 1 = subtract.
- `io_out[4:0]` output 5: `res`, registered result.
- `io_out[5]` output 1: `valid`; `res` holds a completed operation.
- `io_out[7:6]` output 2: `state` encoding.

## Operation

- Strobe path: `stb` passes through `SYNC_STAGES` flops plus one history flop. A load pulse `ld` is synchronised-high AND history-low, so it lasts one cycle per rising edge of `stb`.
- The `op` pin uses the same synchroniser depth. Its synchronised value is sampled only when `ld` is high.
- States:
  - LOAD_A = 2'b00
  - LOAD_B = 2'b01
  - DONE = 2'b10
  - 2'b11 is illegal and recovers to LOAD_A on the next clock.
- State transitions:
  - LOAD_A + `ld`: A <= `d`, go to LOAD_B, `valid` <= 0.
  - LOAD_B + `ld`: B <= `d`, OP <= `op`, `res` <= alu(A, `d`, `op`), `valid` <= 1, go to DONE.
  - DONE + `ld`: behaviour is set by the configuration (see Configuration).
  - No `ld`: hold every register.
- Arithmetic, 4-bit operands, 5-bit result:
  - add: `res` = A + B, with `res[4]` = carry out.
  - subtract: `res` = A + ~B + 1, with `res[4]` = carry out, where 1 means no borrow (A >= B). Examples: 7-3 = 5'b1_0100; 3-7 = 5'b0_1100.
- `res` keeps its value through LOAD_A and LOAD_B until the next completed operation. Only `valid` drops.
- `d` is sampled raw. It must be stable for the full strobe-high window; the bench guarantees this.

## Timing

- Reset values: state LOAD_A, A = B = 0, OP = 0, `res` = 5'b0, `valid` = 0, all synchroniser flops 0.
- If `stb` rises before clock edge k, `ld` is high during the cycle following edge k+`SYNC_STAGES`-1. The register update lands on edge k+`SYNC_STAGES`, which is 2 edges with the default.
- `res`, `valid` and `state` change on that same edge. There is no further pipeline stage.
- `stb` must be high for at least `SYNC_STAGES`+1 clocks and low for at least `SYNC_STAGES`+1 clocks. Shorter pulses may be missed; they never produce a double load.
- Holding `stb` high produces exactly one `ld`.
- Reset asserted mid-sequence immediately forces all reset values. A strobe pulse still in flight is discarded, because the synchroniser is cleared too.
- Outputs are glitch-free: all are driven directly from flops.

## Configuration

- `TT_OPSEQ_CHAIN_EN` defined: DONE + `ld` sets A <= `res[3:0]`, B <= `d`, OP <= `op`, `res` <= alu(`res[3:0]`, `d`, `op`), `valid` stays 1, state stays DONE. This is a running accumulator.
  - Returning to LOAD_A requires reset.
- Not defined: DONE + `ld` sets A <= `d`, `valid` <= 0, and goes to LOAD_B. This starts a fresh pair.
  - `res` holds its previous value.

## Structure

- Package `tt_opseq_pkg`:
  - state typedef and encodings (LOAD_A, LOAD_B, DONE);
  - op constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - widths W_OPND = 4, W_RES = 5.
- Sub-module `tt_opseq_alu4`: purely combinational. Inputs a[3:0], b[3:0], sub. Output y[4:0] computed as a + (b ^ {4{sub}}) + sub, with y[4] = carry out. This is the same arithmetic contract as the downstream adder/subtractor, so the two can be cross-checked.
- Top: synchroniser, edge detector, FSM and output registers.

## Test plan

- Reset then idle: assert `rst` mid-clock with no `stb` -> `io_out` = 8'h00; state stays 2'b00 for 20 clocks.
- Add: `d`=4'h9 + strobe, then `d`=4'h8, `op`=0 + strobe -> after the second load, `res`=5'b1_0001, `valid`=1, state=2'b10.
- Subtract with borrow: A=3, B=7, `op`=1 -> `res`=5'b0_1100. Subtract without borrow: A=7, B=3 -> `res`=5'b1_0100.
- Strobe held high 50 clocks in LOAD_A -> exactly one load; state=2'b01 and does not advance further.
- Reset mid-op: load A=5, raise `stb` for B, assert `rst` one clock after `stb` rises -> all outputs 0, state 2'b00, no late load after release.
- DONE then third strobe with `d`=4'h2, `op`=0 after 9+8:
  - with `TT_OPSEQ_CHAIN_EN`: `res`=5'b0_0011, `valid`=1, state 2'b10;
  - without it: `valid`=0, state 2'b01, `res` holds 5'b1_0001.

Source files
------------

// File: rtl/tt_opseq_pkg.sv
// Shared types and constants for the operand sequencer tile.
package tt_opseq_pkg;

   localparam int unsigned W_OPND = 4;
   localparam int unsigned W_RES  = 5;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      DONE   = 2'b10
   } opseq_state_e;

endpackage

// File: rtl/tt_opseq_alu4.sv
// 4-bit add/subtract core: y = a + (b ^ {4{sub}}) + sub, y[4] is carry out
// (for subtract, carry out 1 means no borrow).
module tt_opseq_alu4
   import tt_opseq_pkg::*;
(
   input  logic [W_OPND-1:0] a_i,
   input  logic [W_OPND-1:0] b_i,
   input  logic              sub_i,
   output logic [W_RES-1:0]  y_o
);

   // Two's-complement add of the optionally inverted b operand.
   always_comb begin
      y_o = {1'b0, a_i} + {1'b0, b_i ^ {W_OPND{sub_i}}} + {{(W_RES-1){1'b0}}, sub_i};
   end

endmodule

// File: rtl/tt_operand_sequencer.sv
// Operand sequencer tile: synchronises a slow load strobe, collects two
// nibbles over a shared bus and registers the add/subtract result.
// Optional macro TT_OPSEQ_CHAIN_EN: loads in DONE accumulate onto the
// previous result instead of starting a fresh operand pair.
module tt_operand_sequencer
   import tt_opseq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic                    clk;
   logic                    rst;
   logic [W_OPND-1:0]       d;

   logic [SYNC_STAGES-1:0]  stb_sync_q;
   logic [SYNC_STAGES-1:0]  op_sync_q;
   logic                    stb_hist_q;
   logic                    ld;
   logic                    op_s;

   opseq_state_e            state_q;
   logic [W_OPND-1:0]       a_q;
   logic [W_OPND-1:0]       b_q;
   logic                    opr_q;
   logic [W_RES-1:0]        res_q;
   logic                    valid_q;

   logic [W_OPND-1:0]       alu_a;
   logic [W_OPND-1:0]       alu_b;
   logic                    alu_sub;
   logic [W_RES-1:0]        alu_y;

   assign clk = io_in[0];
   assign rst = io_in[1];
   assign d   = io_in[5:2];

   // Synchronise strobe and op pins; history flop feeds the rise detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_sync_q <= '0;
         op_sync_q  <= '0;
         stb_hist_q <= 1'b0;
      end else begin
         stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], io_in[6]};
         op_sync_q  <= {op_sync_q[SYNC_STAGES-2:0], io_in[7]};
         stb_hist_q <= stb_sync_q[SYNC_STAGES-1];
      end
   end

   assign ld   = stb_sync_q[SYNC_STAGES-1] & ~stb_hist_q;
   assign op_s = op_sync_q[SYNC_STAGES-1];

   // ALU operands: the incoming nibble/op while loading, else the held operands.
   always_comb begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sub = opr_q;
      if (ld) begin
         alu_b   = d;
         alu_sub = (op_s == OP_SUB);
`ifdef TT_OPSEQ_CHAIN_EN
         if (state_q == DONE) begin
            alu_a = res_q[W_OPND-1:0];
         end
`endif
      end
   end

   tt_opseq_alu4 u_alu (
      .a_i   (alu_a),
      .b_i   (alu_b),
      .sub_i (alu_sub),
      .y_o   (alu_y)
   );

   // Sequencing FSM with operand and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         opr_q   <= OP_ADD;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (ld) begin
                  a_q     <= d;
                  valid_q <= 1'b0;
                  state_q <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (ld) begin
                  b_q     <= d;
                  opr_q   <= op_s;
                  res_q   <= alu_y;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (ld) begin
`ifdef TT_OPSEQ_CHAIN_EN
                  a_q     <= res_q[W_OPND-1:0];
                  b_q     <= d;
                  opr_q   <= op_s;
                  res_q   <= alu_y;
                  valid_q <= 1'b1;
                  state_q <= DONE;
`else
                  a_q     <= d;
                  valid_q <= 1'b0;
                  state_q <= LOAD_B;
`endif
               end
            end
            default: state_q <= LOAD_A;
         endcase
      end
   end

   assign io_out = {state_q, valid_q, res_q};

endmodule

// File: tb/tb_tt_operand_sequencer.sv
// Self-checking bench for tt_operand_sequencer: per-cycle comparison against
// a behavioural model plus hand-computed literal checkpoints.
module tb_tt_operand_sequencer;

   localparam int SYNC = 2;

   logic       clk_r = 1'b0;
   logic       rst_r = 1'b0;
   logic       stb_r = 1'b0;
   logic       op_r  = 1'b0;
   logic [3:0] d_r   = 4'h0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {op_r, stb_r, d_r, rst_r, clk_r};

   tt_operand_sequencer #(.SYNC_STAGES(SYNC)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk_r = ~clk_r;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state (numeric state values follow the tile's state encoding).
   int m_state = 0;
   int m_a     = 0;
   int m_res   = 0;
   int m_valid = 0;
   int pend_cnt = 0;
   int pend_d   = 0;
   int pend_op  = 0;

   function automatic int arith(int a, int b, int op);
      if (op == 0) return a + b;
      return ((a >= b) ? 16 : 0) + ((a - b + 16) % 16);
   endfunction

   task automatic m_apply(int dv, int opv);
      case (m_state)
         0: begin m_a = dv; m_valid = 0; m_state = 1; end
         1: begin m_res = arith(m_a, dv, opv); m_valid = 1; m_state = 2; end
         default: begin
`ifdef TT_OPSEQ_CHAIN_EN
            m_a = m_res % 16;
            m_res = arith(m_a, dv, opv);
            m_valid = 1;
`else
            m_a = dv; m_valid = 0; m_state = 1;
`endif
         end
      endcase
   endtask

   // Model: reset clears everything including an in-flight strobe; a strobe
   // rise takes effect SYNC+1 rising edges after it was driven.
   always @(posedge clk_r or posedge rst_r) begin
      if (rst_r) begin
         m_state = 0; m_a = 0; m_res = 0; m_valid = 0; pend_cnt = 0;
      end else if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         if (pend_cnt == 0) m_apply(pend_d, pend_op);
      end
   end

   // Compare the DUT against the model every cycle, away from the active edge.
   always @(negedge clk_r) begin
      if (chk_en) begin
         logic [7:0] exp_v;
         exp_v = {m_state[1:0], m_valid[0], m_res[4:0]};
         n_chk++;
         if (io_out !== exp_v) begin
            n_err++;
            $display("FAIL model_cmp t=%0t io_out=%h expected=%h", $time, io_out, exp_v);
         end
      end
   end

   task automatic tick();
      @(posedge clk_r);
      #2;
   endtask

   task automatic chk_lit(string name, logic [7:0] exp_v);
      #5;
      n_chk++;
      if (io_out !== exp_v) begin
         n_err++;
         $display("FAIL %s io_out=%h expected=%h", name, io_out, exp_v);
      end
   endtask

   task automatic do_load(logic [3:0] dv, logic opv);
      tick();
      d_r = dv; op_r = opv; stb_r = 1'b1;
      pend_d = int'(dv); pend_op = int'(opv); pend_cnt = SYNC + 1;
      repeat (SYNC + 2) tick();
      stb_r = 1'b0;
      repeat (SYNC + 2) tick();
   endtask

   task automatic do_reset();
      tick();
      rst_r = 1'b1;
      tick();
      tick();
      rst_r = 1'b0;
   endtask

   initial begin
      #1 rst_r = 1'b1;
      repeat (3) tick();
      rst_r = 1'b0;
      chk_en = 1'b1;
      chk_lit("reset_state", 8'h00);
      repeat (20) tick();
      chk_lit("idle_20", 8'h00);

      // 9 + 8 = 17 -> carry set, low nibble 1
      do_load(4'h9, 1'b0);
      chk_lit("after_A9", 8'h40);
      do_load(4'h8, 1'b0);
      chk_lit("add_9_8", 8'hB1);

      // Third strobe from DONE
      do_load(4'h2, 1'b0);
`ifdef TT_OPSEQ_CHAIN_EN
      chk_lit("done_third_chain", 8'hA3);
`else
      chk_lit("done_third_fresh", 8'h51);
`endif

      // 3 - 7: borrow, carry 0
      do_reset();
      chk_lit("reset_again", 8'h00);
      do_load(4'h3, 1'b1);
      do_load(4'h7, 1'b1);
      chk_lit("sub_3_7", 8'hAC);

      // 7 - 3: no borrow, carry 1
      do_reset();
      do_load(4'h7, 1'b1);
      do_load(4'h3, 1'b1);
      chk_lit("sub_7_3", 8'hB4);

      // Strobe held high for 50 clocks: exactly one load
      do_reset();
      tick();
      d_r = 4'h5; op_r = 1'b0; stb_r = 1'b1;
      pend_d = 5; pend_op = 0; pend_cnt = SYNC + 1;
      repeat (50) tick();
      chk_lit("held_strobe", 8'h40);
      stb_r = 1'b0;
      repeat (SYNC + 2) tick();
      chk_lit("held_release", 8'h40);

      // Reset while a strobe is in flight: the pending load is discarded
      do_reset();
      do_load(4'h5, 1'b0);
      tick();
      d_r = 4'h7; stb_r = 1'b1;
      pend_d = 7; pend_op = 0; pend_cnt = SYNC + 1;
      tick();
      rst_r = 1'b1;
      chk_lit("rst_midop_assert", 8'h00);
      tick();
      stb_r = 1'b0;
      repeat (2) tick();
      rst_r = 1'b0;
      repeat (10) tick();
      chk_lit("rst_midop_no_late_load", 8'h00);

      // Subtract equal operands after the recovery: 6 - 6 = 0, no borrow
      do_load(4'h6, 1'b1);
      do_load(4'h6, 1'b1);
      chk_lit("sub_6_6", 8'hB0);

      // 15 + 15 = 30 -> carry, low nibble E
      do_reset();
      do_load(4'hF, 1'b0);
      do_load(4'hF, 1'b0);
      chk_lit("add_F_F", 8'hBE);

      tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
